// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared definitions for the memory-port arbiter: bus command encodings,
//   memory tag width and the owner encoding used by the tag owner table.
package mem_bus_arbiter_pkg;

   localparam int MEM_TAG_BITS = 4;
   localparam int NUM_TAGS     = 1 << MEM_TAG_BITS;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } bus_cmd_e;

   typedef enum logic {
      OWNER_ICACHE = 1'b0,
      OWNER_DCACHE = 1'b1
   } owner_e;

   typedef logic [MEM_TAG_BITS-1:0] mem_tag_t;

   // Any command other than BUS_NONE counts as a request.
   function automatic logic is_request(input logic [1:0] cmd);
      return cmd != BUS_NONE;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Bundles the cache-side request/response signals and the memory-side
//   command/response signals around the arbiter.
//   slave  : the arbiter's view (takes requests and memory replies, drives
//            the memory command and the per-cache replies).
//   master : the surrounding caches/memory view (the opposite directions).
interface mem_bus_arbiter_if;

   // icache controller -> arbiter
   logic [1:0]  Icache2mem_command;
   logic [63:0] Icache2mem_addr;
   // dcache controller -> arbiter
   logic [1:0]  Dcache2Dmem_command;
   logic [63:0] Dcache2Dmem_addr;
   logic [63:0] Dcache2Dmem_data;
   // memory -> arbiter
   logic [mem_bus_arbiter_pkg::MEM_TAG_BITS-1:0] mem2proc_response;
   logic [mem_bus_arbiter_pkg::MEM_TAG_BITS-1:0] mem2proc_tag;
   logic [63:0] mem2proc_data;
   // arbiter -> memory
   logic [1:0]  proc2mem_command;
   logic [63:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   // arbiter -> icache
   logic [mem_bus_arbiter_pkg::MEM_TAG_BITS-1:0] Imem2Icache_response;
   logic [mem_bus_arbiter_pkg::MEM_TAG_BITS-1:0] Imem2Icache_tag;
   logic [63:0] Imem2Icache_data;
   // arbiter -> dcache
   logic [mem_bus_arbiter_pkg::MEM_TAG_BITS-1:0] Dmem2Dcache_response;
   logic [mem_bus_arbiter_pkg::MEM_TAG_BITS-1:0] Dmem2Dcache_tag;
   logic [63:0] Dmem2Dcache_data;
   // completion arrived with no recorded owner
   logic        orphan_tag;

   modport slave (
      input  Icache2mem_command, Icache2mem_addr,
      input  Dcache2Dmem_command, Dcache2Dmem_addr, Dcache2Dmem_data,
      input  mem2proc_response, mem2proc_tag, mem2proc_data,
      output proc2mem_command, proc2mem_addr, proc2mem_data,
      output Imem2Icache_response, Imem2Icache_tag, Imem2Icache_data,
      output Dmem2Dcache_response, Dmem2Dcache_tag, Dmem2Dcache_data,
      output orphan_tag
   );

   modport master (
      output Icache2mem_command, Icache2mem_addr,
      output Dcache2Dmem_command, Dcache2Dmem_addr, Dcache2Dmem_data,
      output mem2proc_response, mem2proc_tag, mem2proc_data,
      input  proc2mem_command, proc2mem_addr, proc2mem_data,
      input  Imem2Icache_response, Imem2Icache_tag, Imem2Icache_data,
      input  Dmem2Dcache_response, Dmem2Dcache_tag, Dmem2Dcache_data,
      input  orphan_tag
   );

endinterface

// File: rtl/mem_tag_owner_table.sv
// mem_tag_owner_table
//   Records which cache owns each outstanding memory tag.
//   Ports:
//     clock, reset       : clock and synchronous active-high reset
//     set_en_i/_tag_i/
//     set_owner_i        : mark an entry valid with the given owner
//     clr_en_i/clr_tag_i : invalidate an entry
//     lookup_tag_i       : combinational lookup address
//     lookup_valid_o/
//     lookup_owner_o     : contents of the looked-up entry (pre-update)
//   Tag 0 means "no tag" on the memory bus, so entry 0 is never written.
module mem_tag_owner_table
   import mem_bus_arbiter_pkg::*;
(
   input  logic     clock,
   input  logic     reset,
   input  logic     set_en_i,
   input  mem_tag_t set_tag_i,
   input  owner_e   set_owner_i,
   input  logic     clr_en_i,
   input  mem_tag_t clr_tag_i,
   input  mem_tag_t lookup_tag_i,
   output logic     lookup_valid_o,
   output owner_e   lookup_owner_o
);

   logic [NUM_TAGS-1:0] valid_q, valid_d;
   logic [NUM_TAGS-1:0] owner_q, owner_d;

   // Clear is applied first so a same-cycle set of the same tag wins.
   always_comb begin
      valid_d = valid_q;
      owner_d = owner_q;
      if (clr_en_i && (clr_tag_i != '0)) begin
         valid_d[clr_tag_i] = 1'b0;
      end
      if (set_en_i && (set_tag_i != '0)) begin
         valid_d[set_tag_i] = 1'b1;
         owner_d[set_tag_i] = set_owner_i;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
         owner_q <= '0;
      end else begin
         valid_q <= valid_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      lookup_valid_o = valid_q[lookup_tag_i];
      lookup_owner_o = owner_e'(owner_q[lookup_tag_i]);
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single main-memory port between the icache and dcache
//   controllers. Grants at most one requester per cycle (dcache preferred,
//   icache forced through after STARVE_LIMIT denied cycles), returns the
//   memory accept tag to the granted requester only, and routes later
//   completions to whichever cache owns the tag.
//   Ports:
//     clock : system clock
//     reset : synchronous active-high reset
//     bus   : all request/response/completion signals (slave modport)
//             including the orphan_tag pulse
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input logic              clock,
   input logic              reset,
   mem_bus_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   logic   icache_req;
   logic   dcache_req;
   logic   grant_icache;
   logic   grant_dcache;
   logic   mem_accept;
   logic   tbl_set_en;
   owner_e tbl_set_owner;
   logic   cpl_valid;
   owner_e cpl_owner;
   logic   cpl_hit;

   // ---------------------------------------------------------------
   // Grant
   // ---------------------------------------------------------------
   always_comb begin
      icache_req   = is_request(bus.Icache2mem_command);
      dcache_req   = is_request(bus.Dcache2Dmem_command);
      // The icache only beats a competing dcache once it has starved.
      grant_icache = icache_req && (!dcache_req || (starve_cnt_q == STARVE_MAX));
      grant_dcache = dcache_req && !grant_icache;
      mem_accept   = bus.mem2proc_response != '0;
   end

   always_comb begin
      bus.proc2mem_command = BUS_NONE;
      bus.proc2mem_addr    = '0;
      bus.proc2mem_data    = '0;
      if (grant_dcache) begin
         bus.proc2mem_command = bus.Dcache2Dmem_command;
         bus.proc2mem_addr    = bus.Dcache2Dmem_addr;
         if (bus.Dcache2Dmem_command == BUS_STORE) begin
            bus.proc2mem_data = bus.Dcache2Dmem_data;
         end
      end else if (grant_icache) begin
         bus.proc2mem_command = bus.Icache2mem_command;
         bus.proc2mem_addr    = bus.Icache2mem_addr;
      end
   end

   // ---------------------------------------------------------------
   // Accept routing: the loser sees 0 and keeps its request up.
   // ---------------------------------------------------------------
   always_comb begin
      bus.Imem2Icache_response = grant_icache ? bus.mem2proc_response : '0;
      bus.Dmem2Dcache_response = grant_dcache ? bus.mem2proc_response : '0;
   end

   // ---------------------------------------------------------------
   // Owner table
   // ---------------------------------------------------------------
   always_comb begin
      tbl_set_en    = (grant_icache || grant_dcache) && mem_accept;
      tbl_set_owner = grant_dcache ? OWNER_DCACHE : OWNER_ICACHE;
   end

   mem_tag_owner_table u_owner_table (
      .clock          (clock),
      .reset          (reset),
      .set_en_i       (tbl_set_en),
      .set_tag_i      (bus.mem2proc_response),
      .set_owner_i    (tbl_set_owner),
      .clr_en_i       (cpl_hit),
      .clr_tag_i      (bus.mem2proc_tag),
      .lookup_tag_i   (bus.mem2proc_tag),
      .lookup_valid_o (cpl_valid),
      .lookup_owner_o (cpl_owner)
   );

   // ---------------------------------------------------------------
   // Completion routing
   // ---------------------------------------------------------------
   always_comb begin
      cpl_hit              = (bus.mem2proc_tag != '0) && cpl_valid;
      bus.orphan_tag       = (bus.mem2proc_tag != '0) && !cpl_valid;
      bus.Imem2Icache_tag  = '0;
      bus.Imem2Icache_data = '0;
      bus.Dmem2Dcache_tag  = '0;
      bus.Dmem2Dcache_data = '0;
      if (cpl_hit) begin
         if (cpl_owner == OWNER_DCACHE) begin
            bus.Dmem2Dcache_tag  = bus.mem2proc_tag;
            bus.Dmem2Dcache_data = bus.mem2proc_data;
         end else begin
            bus.Imem2Icache_tag  = bus.mem2proc_tag;
            bus.Imem2Icache_data = bus.mem2proc_data;
         end
      end
   end

   // ---------------------------------------------------------------
   // Starvation counter: counts icache cycles that did not end in an
   // accepted grant; any idle icache cycle restarts the count.
   // ---------------------------------------------------------------
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!icache_req) begin
         starve_cnt_d = '0;
      end else if (grant_icache && mem_accept) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != STARVE_MAX) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single main-memory port between the instruction-cache controller and the data-cache controller. Each cycle it grants at most one requester, passes the memory's 4-bit response tag back to the granted requester only, and records which requester owns each outstanding tag. When memory later broadcasts a completion tag, the block routes the tag and data to the owning cache only. It sits between both cache controllers and the memory model, and replaces direct wiring of either controller to memory.

## Interface
- STARVE_LIMIT, 4: consecutive cycles the icache may be denied while requesting; once reached, the icache gets priority for one grant.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- Icache2mem_command  in  2  BUS_NONE/BUS_LOAD from the icache controller.
- Icache2mem_addr  in  64  icache request address, 8-byte aligned.
- Dcache2Dmem_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE from the dcache controller.
- Dcache2Dmem_addr  in  64  dcache request address.
- Dcache2Dmem_data  in  64  store data.
- mem2proc_response  in  4  memory accept tag; 0 = rejected.
- mem2proc_tag  in  4  memory completion tag; 0 = none.
- mem2proc_data  in  64  completion data.
- proc2mem_command  out  2  granted command.
- proc2mem_addr  out  64  granted address.
- proc2mem_data  out  64  granted store data; 0 for loads.
- Imem2Icache_response  out  4  accept tag to the icache.
- Imem2Icache_tag  out  4  completion tag to the icache.
- Imem2Icache_data  out  64  completion data to the icache.
- Dmem2Dcache_response  out  4  accept tag to the dcache.
- Dmem2Dcache_tag  out  4  completion tag to the dcache.
- Dmem2Dcache_data  out  64  completion data to the dcache.
- orphan_tag  out  1  one-cycle pulse: a completion tag arrived with no recorded owner.

## Operation
- Grant (combinational):
  - If only one requester has a command other than BUS_NONE, that requester is granted.
  - If both request, the dcache wins, unless starve_cnt == STARVE_LIMIT, in which case the icache wins.
  - The granted requester's command, address and data drive the proc2mem_* outputs.
  - With no requests, proc2mem_command = BUS_NONE, and proc2mem_addr and proc2mem_data are 0.
- Accept routing:
  - The granted requester receives mem2proc_response.
  - The non-granted requester receives a response of 0. It treats this as a rejection and holds its request.
- Owner table: 16 entries, each holding a valid bit and a 1-bit owner (0 = icache, 1 = dcache). Entry 0 is never written.
  - On a nonzero mem2proc_response while a grant is active, the entry at that tag is set valid with the granted owner. This covers both loads and stores.
- Completion routing: when mem2proc_tag is nonzero, look up its entry.
  - If the entry is valid, drive tag and data to the owner's Imem2Icache_* or Dmem2Dcache_* outputs, and drive 0 on the other requester's tag and data. Clear the entry.
  - If the entry is invalid, neither requester sees the completion, and orphan_tag = 1.
- Starvation counter (starve_cnt, range 0..STARVE_LIMIT):
  - Increments, saturating at STARVE_LIMIT, when the icache requests and is not granted, or is granted but its response is 0.
  - Clears to 0 on any icache grant with a nonzero response, or on a cycle with no icache request.

## Timing
- Grant, accept routing and completion routing are combinational, with zero added latency.
- The memory response must arrive in the same cycle as the request, matching the memory model.
- The table and counter update at the clock edge after the event.
- Simultaneous clear and set of the same tag in one cycle: the set wins, and the entry takes the new owner.
- A completion in the same cycle as a new accept is supported. Both paths are independent.
- Reset:
  - Clears every table entry and sets starve_cnt = 0.
  - All outputs follow the combinational rules above. With idle inputs, every output is 0 or BUS_NONE.
  - Reset mid-transaction drops all ownership, so later completions of those tags pulse orphan_tag.
- A requester may change its address while being rejected. The block keeps no request state.

## Structure
- The shared package holds:
  - the BUS_NONE, BUS_LOAD and BUS_STORE encodings;
  - MEM_TAG_BITS = 4;
  - the owner encoding OWNER_ICACHE = 0 and OWNER_DCACHE = 1.
- One sub-module, mem_tag_owner_table:
  - a 16-entry valid/owner array;
  - one set port and one clear port, with set priority;
  - one combinational lookup port.
- Grant logic and starve_cnt stay in the top level.

## Test plan
- Dcache BUS_LOAD to 0x100 only; response 3 -> Dmem2Dcache_response = 3 and Imem2Icache_response = 0. Later mem2proc_tag = 3 with data 0xDEAD -> Dmem2Dcache_tag = 3, data 0xDEAD; icache tag = 0.
- Both request every cycle, memory always accepts, STARVE_LIMIT = 4 -> dcache granted 4 cycles, icache granted on the 5th, then starve_cnt = 0.
- Icache accepted with tag 5, then dcache accepted with tag 6. Completions 6 then 5 -> each is delivered only to its owner, and both entries end invalid.
- Completion tag 7 and new accept tag 7 (icache) in the same cycle, where entry 7 was owned by the dcache -> dcache receives completion 7, and entry 7 becomes valid with owner icache.
- Reset asserted while tag 2 is outstanding; after release, mem2proc_tag = 2 -> orphan_tag pulses and both requester tags are 0.
- Dcache BUS_STORE, addr 0x40, data 0x55, response 9 -> proc2mem_data = 0x55 and entry 9 is owned by the dcache. Memory rejects (response 0) -> no table write.
